ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL be reset rst, synchronous, active-high; all state changes on rising clk.
REQ-002 clk  in  1  pipeline clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 funct  in  6  operation code from decode (MIPS SPECIAL funct encoding).
REQ-005 operand_1  in  32  rs value (A).
REQ-006 operand_2  in  32  rt value or zero-extended immediate (B).
REQ-007 shamt  in  5  shift amount.
REQ-008 write_reg_en_i / write_reg_addr_i  in  1/5  GPR write request from decode.
REQ-009 result  out  32  registered ALU result to memory stage.
REQ-010 write_reg_en / write_reg_addr  out  1/5  registered GPR write request.
REQ-011 stall_req  out  1  combinational; high means decode SHALL hold its outputs stable.
REQ-012 hi / lo  out  32/32  current HI/LO register contents.

Function
REQ-013 Funct codes: SLL 00, SRL 02, SRA 03, MFHI 10, MTHI 11, MFLO 12, MTLO 13, MULT 18, MULTU 19, DIV 1A, DIVU 1B, ADDU 21, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLTU 2B; any other code yields result 0.
REQ-014 Shifts operate on B by shamt; SRA sign-fills; ADDU/SUBU wrap modulo 2^32 with no overflow trap.
REQ-015 SLT signed and SLTU unsigned compare A<B; result 1 or 0 zero-extended.
REQ-016 Single-cycle ops: result, write_reg_en, write_reg_addr register the computed value and decode inputs at the next edge (latency 1).
REQ-017 MFHI/MFLO return the HI/LO value current in that cycle; MTHI/MTLO write A into HI/LO at the edge.
REQ-018 MULT (signed) / MULTU: 64-bit product written at the edge, HI=[63:32], LO=[31:0]; no stall.
REQ-019 Divider FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-020 IDLE with DIV/DIVU on funct: stall_req high, latch |A|,|B| (signed) or A,B (unsigned) and sign flags, go BUSY, count=0.
REQ-021 BUSY: one restoring shift-subtract step per cycle, stall_req high, 32 cycles, then DONE.
REQ-022 DONE: stall_req low, LO=quotient, HI=remainder written at edge, return IDLE.
REQ-023 Signed fix-up: quotient negated if operand signs differ; remainder takes sign of dividend.
REQ-024 Divide by zero: IDLE goes directly to DONE (stall 1 cycle); LO=FFFFFFFF, HI=A.
REQ-025 DIV total occupancy 34 cycles in EX (IDLE + 32 BUSY + DONE); stall_req high 33 cycles.
REQ-026 While stall_req high, outputs register a bubble: write_reg_en=0, write_reg_addr=0, result=0.
REQ-027 DIV/DIVU/MULT/MULTU/MTHI/MTLO never assert write_reg_en regardless of write_reg_en_i.
REQ-028 write_reg_addr 0 forces write_reg_en output to 0.
REQ-029 MULT, MTHI or MTLO in same cycle as divider in DONE cannot occur (decode stalled); no priority needed.
REQ-030 HI/LO hold value when no HI/LO-writing op completes.

Reset
REQ-031 On rst: result=0, write_reg_en=0, write_reg_addr=0, HI=0, LO=0, FSM=IDLE, count=0.
REQ-032 rst during BUSY aborts the division; HI/LO become 0 and stall_req drops in the same cycle rst is sampled.
REQ-033 stall_req is 0 while rst is high.

Verification
REQ-034 ORI-style OR: A=0000_1234, B=0000_00F0, funct 25, wen=1, addr 5 -> next cycle result=0000_12F4, wen=1, addr=5.
REQ-035 SRA: B=8000_0000, shamt=4 -> result=F800_0000; SLT A=FFFF_FFFF, B=1 -> 1; SLTU same -> 0.
REQ-036 MULT A=FFFF_FFFE(-2), B=3 -> HI=FFFF_FFFF, LO=FFFF_FFFA; then MFLO -> result=FFFF_FFFA.
REQ-037 DIV A=FFFF_FFF9(-7), B=2 -> stall_req high 33 cycles, then LO=FFFF_FFFD(-3), HI=FFFF_FFFF(-1); DIVU 7/2 -> LO=3, HI=1.
REQ-038 DIVU B=0, A=0000_0010 -> stall 1 cycle, LO=FFFF_FFFF, HI=0000_0010.
REQ-039 rst asserted at BUSY cycle 10 -> next cycle FSM IDLE, stall_req 0, HI=LO=0, wen=0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, HI/LO register pair, single-cycle multiplier
// and a 32-step restoring divider that stalls decode while it runs.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic [4:0]  shamt,
    input  logic        write_reg_en_i,
    input  logic [4:0]  write_reg_addr_i,
    output logic [31:0] result,
    output logic        write_reg_en,
    output logic [4:0]  write_reg_addr,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    div_state_e  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] result_q, result_d;
    logic        wen_q, wen_d;
    logic [4:0]  addr_q, addr_d;

    logic        is_div, is_signed_div, no_wen_op;
    logic [31:0] abs_a, abs_b, alu_res;
    logic [63:0] ext_a, ext_b, prod;
    logic [32:0] rem_shift, rem_sub;

    assign is_div        = (funct == F_DIV) || (funct == F_DIVU);
    assign is_signed_div = (funct == F_DIV);
    assign no_wen_op     = is_div || (funct == F_MULT) || (funct == F_MULTU) ||
                           (funct == F_MTHI) || (funct == F_MTLO);

    assign abs_a = operand_1[31] ? (~operand_1 + 32'd1) : operand_1;
    assign abs_b = operand_2[31] ? (~operand_2 + 32'd1) : operand_2;

    // Low 64 bits of the product are exact once the operands are extended to 64 bits.
    assign ext_a = (funct == F_MULT) ? {{32{operand_1[31]}}, operand_1} : {32'd0, operand_1};
    assign ext_b = (funct == F_MULT) ? {{32{operand_2[31]}}, operand_2} : {32'd0, operand_2};
    assign prod  = ext_a * ext_b;

    always_comb begin
        alu_res = '0;
        case (funct)
            F_SLL:  alu_res = operand_2 << shamt;
            F_SRL:  alu_res = operand_2 >> shamt;
            F_SRA:  alu_res = $unsigned($signed(operand_2) >>> shamt);
            F_MFHI: alu_res = hi_q;
            F_MFLO: alu_res = lo_q;
            F_ADDU: alu_res = operand_1 + operand_2;
            F_SUBU: alu_res = operand_1 - operand_2;
            F_AND:  alu_res = operand_1 & operand_2;
            F_OR:   alu_res = operand_1 | operand_2;
            F_XOR:  alu_res = operand_1 ^ operand_2;
            F_NOR:  alu_res = ~(operand_1 | operand_2);
            F_SLT:  alu_res = {31'd0, $signed(operand_1) < $signed(operand_2)};
            F_SLTU: alu_res = {31'd0, operand_1 < operand_2};
            default: alu_res = '0;
        endcase
    end

    // Quotient register doubles as the dividend shift register during BUSY.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        stall_req  = 1'b0;
        rem_shift  = {rem_q, quot_q[31]};
        rem_sub    = rem_shift - {1'b0, divisor_q};

        case (state_q)
            S_IDLE: begin
                if (is_div) begin
                    stall_req = 1'b1;
                    if (operand_2 == 32'd0) begin
                        quot_d     = '1;
                        rem_d      = operand_1;
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        quot_d     = is_signed_div ? abs_a : operand_1;
                        divisor_d  = is_signed_div ? abs_b : operand_2;
                        rem_d      = '0;
                        neg_quot_d = is_signed_div && (operand_1[31] ^ operand_2[31]);
                        neg_rem_d  = is_signed_div && operand_1[31];
                        count_d    = '0;
                        state_d    = S_BUSY;
                    end
                end else begin
                    case (funct)
                        F_MTHI:          hi_d = operand_1;
                        F_MTLO:          lo_d = operand_1;
                        F_MULT, F_MULTU: {hi_d, lo_d} = prod;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                stall_req = 1'b1;
                if (!rem_sub[32]) begin
                    rem_d  = rem_sub[31:0];
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = rem_shift[31:0];
                    quot_d = {quot_q[30:0], 1'b0};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) state_d = S_DONE;
            end
            S_DONE: begin
                lo_d    = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
                hi_d    = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) stall_req = 1'b0;
    end

    always_comb begin
        result_d = alu_res;
        wen_d    = write_reg_en_i && (write_reg_addr_i != 5'd0) && !no_wen_op;
        addr_d   = write_reg_addr_i;
        if (stall_req) begin
            result_d = '0;
            wen_d    = 1'b0;
            addr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            result_q   <= '0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            result_q   <= result_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
        end
    end

    assign result         = result_q;
    assign write_reg_en   = wen_q;
    assign write_reg_addr = addr_q;
    assign hi             = hi_q;
    assign lo             = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written divider / reset sequences.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  funct;
    logic [31:0] operand_1, operand_2;
    logic [4:0]  shamt;
    logic        write_reg_en_i;
    logic [4:0]  write_reg_addr_i;
    logic [31:0] result, hi, lo;
    logic        write_reg_en;
    logic [4:0]  write_reg_addr;
    logic        stall_req;

    int checks   = 0;
    int failures = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk              (clk),
        .rst              (rst),
        .funct            (funct),
        .operand_1        (operand_1),
        .operand_2        (operand_2),
        .shamt            (shamt),
        .write_reg_en_i   (write_reg_en_i),
        .write_reg_addr_i (write_reg_addr_i),
        .result           (result),
        .write_reg_en     (write_reg_en),
        .write_reg_addr   (write_reg_addr),
        .stall_req        (stall_req),
        .hi               (hi),
        .lo               (lo)
    );

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] exp_res;
        logic        exp_wen;
    } vec_t;

    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic wen, input logic [4:0] addr);
        funct            = f;
        operand_1        = a;
        operand_2        = b;
        shamt            = sh;
        write_reg_en_i   = wen;
        write_reg_addr_i = addr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic wen, input logic [4:0] addr,
                           input logic [31:0] exp_res, input logic exp_wen);
        vecs.push_back(vec_t'{f, a, b, sh, wen, addr, exp_res, exp_wen});
    endtask

    function automatic logic [31:0] model_res(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh,
                                              input logic [31:0] h, input logic [31:0] l);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (f)
            6'h00: return 32'(ub * (64'd1 << sh));
            6'h02: return 32'(ub / (64'd1 << sh));
            6'h03: return 32'(sb >>> sh);
            6'h10: return h;
            6'h12: return l;
            6'h21: return 32'(ua + ub);
            6'h23: return 32'(ua - ub);
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: return (ua < ub) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int n;
        int exp_n;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            q = 32'(longint'($signed(a)) / longint'($signed(b)));
            r = 32'(longint'($signed(a)) % longint'($signed(b)));
        end else begin
            q = a / b;
            r = a % b;
        end
        exp_n = (b == 32'd0) ? 1 : 33;
        drive(sgn ? 6'h1A : 6'h1B, a, b, 5'd0, 1'b1, 5'd7);
        n = 0;
        #1;
        while (stall_req === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check32("div_stall_cycles", 32'(n), 32'(exp_n));
        check1("div_bubble_wen", write_reg_en, 1'b0);
        check32("div_bubble_result", result, 32'd0);
        check32("div_bubble_addr", 32'(write_reg_addr), 32'd0);
        @(posedge clk);
        #1;
        check32("div_lo", lo, q);
        check32("div_hi", hi, r);
        check1("div_no_wen", write_reg_en, 1'b0);
        hi_m = r;
        lo_m = q;
        drive(6'h21, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0);
    endtask

    logic [5:0] ops [18] = '{6'h00, 6'h02, 6'h03, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19,
                             6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};

    initial begin
        rst = 1'b1;
        drive(6'h1A, 32'd7, 32'd2, 5'd0, 1'b0, 5'd0);
        tick();
        check1("stall_in_reset", stall_req, 1'b0);
        drive(6'h21, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0);
        tick();
        check32("rst_result", result, 32'd0);
        check1("rst_wen", write_reg_en, 1'b0);
        check32("rst_addr", 32'(write_reg_addr), 32'd0);
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        rst = 1'b0;
        #1;
        check1("rst_stall_idle", stall_req, 1'b0);

        add_vec(6'h25, 32'h0000_1234, 32'h0000_00F0, 5'd0,  1'b1, 5'd5,  32'h0000_12F4, 1'b1);
        add_vec(6'h03, 32'h0,         32'h8000_0000, 5'd4,  1'b1, 5'd3,  32'hF800_0000, 1'b1);
        add_vec(6'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  1'b1, 5'd4,  32'h0000_0001, 1'b1);
        add_vec(6'h2B, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  1'b1, 5'd4,  32'h0000_0000, 1'b1);
        add_vec(6'h00, 32'h0,         32'h0000_0001, 5'd31, 1'b1, 5'd6,  32'h8000_0000, 1'b1);
        add_vec(6'h02, 32'h0,         32'h8000_0000, 5'd31, 1'b1, 5'd6,  32'h0000_0001, 1'b1);
        add_vec(6'h21, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0,  1'b1, 5'd8,  32'h0000_0001, 1'b1);
        add_vec(6'h23, 32'h0000_0000, 32'h0000_0001, 5'd0,  1'b1, 5'd8,  32'hFFFF_FFFF, 1'b1);
        add_vec(6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  1'b1, 5'd10, 32'hF000_F000, 1'b1);
        add_vec(6'h26, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  1'b1, 5'd11, 32'h0FF0_0FF0, 1'b1);
        add_vec(6'h27, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  1'b1, 5'd12, 32'h000F_000F, 1'b1);
        add_vec(6'h3F, 32'h0000_1234, 32'h0000_0005, 5'd0,  1'b1, 5'd9,  32'h0000_0000, 1'b1);
        add_vec(6'h21, 32'h0000_0001, 32'h0000_0001, 5'd0,  1'b1, 5'd0,  32'h0000_0002, 1'b0);
        add_vec(6'h03, 32'h0,         32'h4000_0000, 5'd4,  1'b1, 5'd13, 32'h0400_0000, 1'b1);
        add_vec(6'h2A, 32'h0000_0005, 32'h0000_0005, 5'd0,  1'b1, 5'd14, 32'h0000_0000, 1'b1);
        add_vec(6'h2B, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  1'b1, 5'd15, 32'h0000_0001, 1'b1);
        add_vec(6'h25, 32'h0000_0001, 32'h0000_0002, 5'd0,  1'b0, 5'd16, 32'h0000_0003, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].wen, vecs[i].addr);
            tick();
            check32("vec_result", result, vecs[i].exp_res);
            check1("vec_wen", write_reg_en, vecs[i].exp_wen);
            check32("vec_addr", 32'(write_reg_addr), 32'(vecs[i].addr));
        end

        // MULT of -2 by 3, then read LO back.
        drive(6'h18, 32'hFFFF_FFFE, 32'h0000_0003, 5'd0, 1'b1, 5'd2);
        tick();
        check32("mult_hi", hi, 32'hFFFF_FFFF);
        check32("mult_lo", lo, 32'hFFFF_FFFA);
        check1("mult_no_wen", write_reg_en, 1'b0);
        drive(6'h12, 32'd0, 32'd0, 5'd0, 1'b1, 5'd2);
        tick();
        check32("mflo_result", result, 32'hFFFF_FFFA);
        check1("mflo_wen", write_reg_en, 1'b1);
        hi_m = 32'hFFFF_FFFF;
        lo_m = 32'hFFFF_FFFA;

        run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        run_div(1'b0, 32'h0000_0007, 32'h0000_0002);
        run_div(1'b0, 32'h0000_0010, 32'h0000_0000);
        run_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
        run_div(1'b1, 32'hFFFF_FFF0, 32'h0000_0000);

        for (int i = 0; i < 150; i++) begin
            logic [5:0]  f;
            logic [31:0] a, b, exp_r;
            logic [4:0]  sh, addr;
            logic        wen, exp_w, has_res;
            longint      sp;
            f    = ops[$urandom_range(17, 0)];
            a    = $urandom;
            b    = ($urandom_range(7, 0) == 0) ? a : $urandom;
            sh   = 5'($urandom_range(31, 0));
            wen  = 1'($urandom_range(1, 0));
            addr = 5'($urandom_range(31, 0));
            has_res = !(f == 6'h11 || f == 6'h13 || f == 6'h18 || f == 6'h19);
            exp_r   = model_res(f, a, b, sh, hi_m, lo_m);
            exp_w   = wen && (addr != 5'd0) && has_res;
            drive(f, a, b, sh, wen, addr);
            tick();
            case (f)
                6'h11: hi_m = a;
                6'h13: lo_m = a;
                6'h18: begin
                    sp   = longint'($signed(a)) * longint'($signed(b));
                    hi_m = sp[63:32];
                    lo_m = sp[31:0];
                end
                6'h19: {hi_m, lo_m} = {32'd0, a} * {32'd0, b};
                default: ;
            endcase
            if (has_res) check32("rand_result", result, exp_r);
            check1("rand_wen", write_reg_en, exp_w);
            check32("rand_addr", 32'(write_reg_addr), 32'(addr));
            check32("rand_hi", hi, hi_m);
            check32("rand_lo", lo, lo_m);
        end

        for (int i = 0; i < 6; i++) begin
            logic        sgn;
            logic [31:0] a, b;
            sgn = 1'($urandom_range(1, 0));
            a   = $urandom;
            case ($urandom_range(5, 0))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(50, 1);
                default: b = $urandom;
            endcase
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            run_div(sgn, a, b);
            drive(6'h10, 32'd0, 32'd0, 5'd0, 1'b1, 5'd20);
            tick();
            check32("mfhi_after_div", result, hi_m);
            drive(6'h21, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0);
        end

        // Abort a division partway through BUSY with reset.
        drive(6'h1A, 32'h1234_5678, 32'h0000_0013, 5'd0, 1'b1, 5'd3);
        tick();
        for (int i = 0; i < 9; i++) tick();
        check1("busy_stall", stall_req, 1'b1);
        rst = 1'b1;
        drive(6'h21, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0);
        #1;
        check1("abort_stall_in_rst", stall_req, 1'b0);
        tick();
        check32("abort_hi", hi, 32'd0);
        check32("abort_lo", lo, 32'd0);
        check1("abort_wen", write_reg_en, 1'b0);
        rst = 1'b0;
        #1;
        check1("abort_stall_after", stall_req, 1'b0);
        hi_m = '0;
        lo_m = '0;
        run_div(1'b0, 32'h0000_0007, 32'h0000_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
